mdu: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS core, alongside the single-cycle `ALU` in the execute stage. It takes the operations the ALU does not perform (MULT, MULTU, DIV, DIVU, MTHI, MTLO), computes them iteratively over many cycles, and holds the HI/LO result pair. The hazard unit reads `busy` to stall MFHI/MFLO and further MDU issues until a result is ready.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_div_core.sv | 49 ++++
 rtl/mdu.sv | 177 +++++++++++++++++
 tb/tb_mdu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and constants for the multi-cycle multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int unsigned ITER      = 32;
    localparam int unsigned DIV_CNT_W = 6;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Two's-complement negate when neg is set; 2^31 round-trips as an unsigned magnitude.
    function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
        return neg ? 32'(~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath: one unsigned quotient bit per step, done flags the final step.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        done
);

    logic [31:0]          dsr_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic [32:0]          rem_sh_c;
    logic                 ge_c;
    logic [31:0]          diff_c;

    // The true difference fits in 32 bits whenever the subtraction is taken.
    assign rem_sh_c = {rem, quo[31]};
    assign ge_c     = rem_sh_c >= {1'b0, dsr_q};
    assign diff_c   = rem_sh_c[31:0] - dsr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo   <= '0;
            rem   <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (load) begin
            quo   <= dividend;
            rem   <= '0;
            dsr_q <= divisor;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (step && (cnt_q != DIV_CNT_W'(ITER))) begin
            rem   <= ge_c ? diff_c : rem_sh_c[31:0];
            quo   <= {quo[30:0], ge_c};
            cnt_q <= cnt_q + DIV_CNT_W'(1);
            // High during the cycle whose edge performs the last step.
            done  <= (cnt_q == DIV_CNT_W'(ITER - 2));
        end
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO.
// Define MDU_FAST_MUL_EN to replace the shift-add multiplier with a retimed '*' of FAST_MUL_LAT cycles.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned FAST_MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_MAX = (FAST_MUL_LAT > ITER) ? FAST_MUL_LAT : ITER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              sign_a_q, sign_r_q, is_mul_q, div0_q;
    logic [31:0]       mag_a_q;

    logic              signed_op_c;
    logic [31:0]       mag_a_c, mag_b_c;
    logic              cap_c, div_load_c, div_step_c, mul_step_c, fix_c, mthi_c, mtlo_c;
    logic [63:0]       prod_res_c;

    logic [31:0]       div_quo, div_rem;
    logic              div_done;

    assign signed_op_c = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a_c     = cond_neg32(a, signed_op_c && a[31]);
    assign mag_b_c     = cond_neg32(b, signed_op_c && b[31]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        cap_c      = 1'b0;
        div_load_c = 1'b0;
        div_step_c = 1'b0;
        mul_step_c = 1'b0;
        fix_c      = 1'b0;
        mthi_c     = 1'b0;
        mtlo_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            cap_c = 1'b1;
`ifdef MDU_FAST_MUL_EN
                            state_d = (FAST_MUL_LAT <= 2) ? FIX : MUL;
`else
                            state_d = MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            cap_c      = 1'b1;
                            div_load_c = 1'b1;
                            state_d    = DIV;
                        end
                        OP_MTHI: mthi_c = 1'b1;
                        OP_MTLO: mtlo_c = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL: begin
`ifdef MDU_FAST_MUL_EN
                if ((32'(cnt_q) + 32'd3) >= FAST_MUL_LAT) state_d = FIX;
`else
                mul_step_c = 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
`endif
            end
            DIV: begin
                div_step_c = 1'b1;
                if (div_done) state_d = FIX;
            end
            FIX: begin
                fix_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_r_q <= 1'b0;
            is_mul_q <= 1'b0;
            div0_q   <= 1'b0;
            mag_a_q  <= '0;
            busy     <= 1'b0;
        end else begin
            if (cap_c) begin
                sign_a_q <= signed_op_c && a[31];
                sign_r_q <= signed_op_c && (a[31] ^ b[31]);
                is_mul_q <= (op == OP_MULT) || (op == OP_MULTU);
                div0_q   <= (b == 32'd0);
                mag_a_q  <= mag_a_c;
            end
            if (cap_c)                 cnt_q <= '0;
            else if (state_q == MUL)   cnt_q <= cnt_q + CNT_W'(1);
            busy <= (state_d != IDLE);
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [31:0] mag_b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      mag_b_q <= '0;
        else if (cap_c) mag_b_q <= mag_b_c;
    end

    // Operands are held stable for the whole wait, so the multiplier can be retimed into it.
    assign prod_res_c = 64'(mag_a_q) * 64'(mag_b_q);
`else
    logic [63:0] prod_q;
    logic [32:0] sum_c;

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
    assign sum_c = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mag_a_q} : 33'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           prod_q <= '0;
        else if (cap_c)      prod_q <= {32'd0, mag_b_c};
        else if (mul_step_c) prod_q <= {sum_c, prod_q[31:1]};
    end

    assign prod_res_c = prod_q;
`endif

    mdu_div_core u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load_c),
        .step     (div_step_c),
        .dividend (mag_a_c),
        .divisor  (mag_b_c),
        .quo      (div_quo),
        .rem      (div_rem),
        .done     (div_done)
    );

    // HI/LO change only on the FIX edge or an idle MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_c) begin
            if (is_mul_q) begin
                {hi, lo} <= sign_r_q ? 64'(~prod_res_c + 64'd1) : prod_res_c;
            end else begin
                hi <= cond_neg32(div_rem, sign_a_q);
                lo <= div0_q ? DIV0_QUO : cond_neg32(div_quo, sign_r_q);
            end
        end else if (mthi_c) begin
            hi <= a;
        end else if (mtlo_c) begin
            lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the mdu multiply/divide unit.
`timescale 1ns/1ps
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_fail;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 4;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns 1 ns after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until busy drops; -1 if it never does.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (busy && cyc < 200);
        if (busy) cyc = -1;
    endtask

    task automatic test_reset;
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (hi !== 32'd0)    begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 32'd0)    begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic test_mult;
        int lat;
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy got=%b exp=1", busy); end
        wait_idle(lat);
        n_cmp++; if (lat != MUL_LAT)         begin n_fail++; $display("FAIL mult_lat got=%0d exp=%0d", lat, MUL_LAT); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF)   begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFA)   begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    endtask

    task automatic test_multu;
        int lat;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(lat);
        n_cmp++; if (lat != MUL_LAT)         begin n_fail++; $display("FAIL multu_lat got=%0d exp=%0d", lat, MUL_LAT); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE)   begin n_fail++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001)   begin n_fail++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div;
        int lat;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy got=%b exp=1", busy); end
        wait_idle(lat);
        n_cmp++; if (lat != DIV_LAT)         begin n_fail++; $display("FAIL div_lat got=%0d exp=%0d", lat, DIV_LAT); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD)   begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF)   begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(lat);
        n_cmp++; if (lo !== 32'h7FFF_FFFC)   begin n_fail++; $display("FAIL divu_lo got=%h exp=7ffffffc", lo); end
        n_cmp++; if (hi !== 32'h0000_0001)   begin n_fail++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
    endtask

    task automatic test_div_boundary;
        int lat;
        issue(3'd3, 32'h0000_1234, 32'd0);
        wait_idle(lat);
        n_cmp++; if (hi !== 32'h0000_1234)   begin n_fail++; $display("FAIL divu0_hi got=%h exp=00001234", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF)   begin n_fail++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo); end
        issue(3'd2, 32'hFFFF_FFFB, 32'd0);
        wait_idle(lat);
        n_cmp++; if (hi !== 32'hFFFF_FFFB)   begin n_fail++; $display("FAIL div0_hi got=%h exp=fffffffb", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF)   begin n_fail++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(lat);
        n_cmp++; if (lo !== 32'h8000_0000)   begin n_fail++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        n_cmp++; if (hi !== 32'h0000_0000)   begin n_fail++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
        issue(3'd0, 32'h8000_0000, 32'h8000_0000);
        wait_idle(lat);
        n_cmp++; if (hi !== 32'h4000_0000)   begin n_fail++; $display("FAIL mulmin_hi got=%h exp=40000000", hi); end
        n_cmp++; if (lo !== 32'h0000_0000)   begin n_fail++; $display("FAIL mulmin_lo got=%h exp=00000000", lo); end
    endtask

    task automatic test_mthi_busy;
        int lat;
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        n_cmp++; if (hi !== 32'hDEAD_BEEF)   begin n_fail++; $display("FAIL mthi_hi got=%h exp=deadbeef", hi); end
        n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        issue(3'd5, 32'h0000_1111, 32'd0);
        n_cmp++; if (lo !== 32'h0000_1111)   begin n_fail++; $display("FAIL mtlo_lo got=%h exp=00001111", lo); end
        issue(3'd0, 32'd2, 32'd3);
        issue(3'd5, 32'd5, 32'd0);
        n_cmp++; if (hi !== 32'hDEAD_BEEF)   begin n_fail++; $display("FAIL hold_hi got=%h exp=deadbeef", hi); end
        n_cmp++; if (lo !== 32'h0000_1111)   begin n_fail++; $display("FAIL ignored_mtlo got=%h exp=00001111", lo); end
        n_cmp++; if (busy !== 1'b1)          begin n_fail++; $display("FAIL mid_busy got=%b exp=1", busy); end
        wait_idle(lat);
        n_cmp++; if (lat < 0)                begin n_fail++; $display("FAIL mthi_mul_timeout got=%0d exp=done", lat); end
        n_cmp++; if (hi !== 32'd0)           begin n_fail++; $display("FAIL mul23_hi got=%h exp=00000000", hi); end
        n_cmp++; if (lo !== 32'd6)           begin n_fail++; $display("FAIL mul23_lo got=%h exp=00000006", lo); end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(3'd1, 32'd7, 32'd6);
        wait_idle(lat);
        issue(3'd2, 32'd100, 32'hFFFF_FFF9);
        n_cmp++; if (lo !== 32'd42)          begin n_fail++; $display("FAIL b2b_mul_lo got=%h exp=0000002a", lo); end
        n_cmp++; if (busy !== 1'b1)          begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        wait_idle(lat);
        n_cmp++; if (lo !== 32'hFFFF_FFF2)   begin n_fail++; $display("FAIL b2b_div_lo got=%h exp=fffffff2", lo); end
        n_cmp++; if (hi !== 32'd2)           begin n_fail++; $display("FAIL b2b_div_hi got=%h exp=00000002", hi); end
        issue(3'd6, 32'd99, 32'd99);
        n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL noop_busy got=%b exp=0", busy); end
        n_cmp++; if (lo !== 32'hFFFF_FFF2)   begin n_fail++; $display("FAIL noop_lo got=%h exp=fffffff2", lo); end
    endtask

    task automatic test_reset_mid;
        int lat;
        issue(3'd2, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        n_cmp++; if (hi !== 32'd0)           begin n_fail++; $display("FAIL rst_mid_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 32'd0)           begin n_fail++; $display("FAIL rst_mid_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset = 1'b0;
        issue(3'd1, 32'd4, 32'd5);
        wait_idle(lat);
        n_cmp++; if (lat != MUL_LAT)         begin n_fail++; $display("FAIL post_rst_lat got=%0d exp=%0d", lat, MUL_LAT); end
        n_cmp++; if (lo !== 32'd20)          begin n_fail++; $display("FAIL post_rst_lo got=%h exp=00000014", lo); end
        n_cmp++; if (hi !== 32'd0)           begin n_fail++; $display("FAIL post_rst_hi got=%h exp=00000000", hi); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        test_mult;
        test_multu;
        test_div;
        test_div_boundary;
        test_mthi_busy;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
